cpu_bus_dma: RTL
================

# cpu_bus_dma

Parametrised CPU-side bus controller that supersedes the fixed CPU memory map. It decodes CPU bus cycles onto work RAM (mirrored), PRG ROM (mirrored by size), the PPU register window and the OAM-DMA trigger. It owns a sprite-DMA engine that stalls the CPU and copies a 256-byte page into the PPU OAMDATA register. It sits between the CPU core and the RAM/ROM macros and the PPU register interface.

## Interface
- RAM_AW, 11: work RAM address width; RAM window $0000–$1FFF mirrors every 2^RAM_AW bytes
- ROM_AW, 15: PRG ROM address width; window $8000–$FFFF; ROM_AW=14 mirrors $C000 onto $8000
- REG_SEL_W, 3: PPU register index width; window $2000–$3FFF mirrors every 2^REG_SEL_W bytes
- DMA_TRIG, 16'h4014: write address that starts DMA
- DMA_DST, 3'h4: register index DMA writes to (OAMDATA)
- DMA_LEN, 256: bytes per DMA, 1..256
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clock_en  in  1  CPU-cycle enable; all state advances only when high
- cpu_addr  in  16  CPU address
- cpu_r_en  in  1  1 = read, 0 = write
- cpu_w_data  in  8  CPU write data
- cpu_r_data  out  8  read data, valid the cycle after the read
- cpu_stall  out  1  CPU must hold its current cycle
- dma_active  out  1  DMA engine owns the bus
- ram_addr / ram_wdata / ram_rden / ram_wren  out  RAM_AW/8/1/1  RAM port, 1-cycle read latency
- ram_rdata  in  8
- rom_addr / rom_rden  out  ROM_AW/1  ROM port, 1-cycle read latency
- rom_rdata  in  8
- reg_sel / reg_en / reg_rw / reg_data_wr  out  REG_SEL_W/1/1/8  PPU register port; reg_rw 1 = write
- reg_data_rd  in  8

## Operation
- Bus master mux: in IDLE the CPU drives the address, read enable and write data; otherwise the DMA engine does.
- Decode:
  - below $2000 → RAM, offset addr[RAM_AW-1:0]
  - $2000–$3FFF → reg_en, reg_sel = addr[REG_SEL_W-1:0]
  - DMA_TRIG write → DMA start; DMA_TRIG read → unmapped
  - $8000+ → ROM, offset addr[ROM_AW-1:0]
  - anything else → unmapped
- Writes to ROM or unmapped addresses are dropped.
- Read source is registered each enabled cycle. cpu_r_data is muxed from ram_rdata, rom_rdata or reg_data_rd by that registered source.
- Unmapped reads return open bus: the last value driven on cpu_r_data, held in a register.
- FSM states IDLE, DUMMY, ALIGN, READ, WRITE.
  - IDLE → DUMMY on a CPU write to DMA_TRIG. Latch page P = cpu_w_data and clear byte counter i.
  - DUMMY → READ if the next cycle parity is even, else → ALIGN.
  - ALIGN → READ.
  - READ: issue a read of {P, i[7:0]} through the normal decode (RAM, ROM, reg or open bus). → WRITE.
  - WRITE: reg_en=1, reg_rw=1, reg_sel=DMA_DST, reg_data_wr = the byte read in the previous cycle. Then i++; → IDLE if i==DMA_LEN-1, else → READ.
- Parity: a 1-bit counter toggled every enabled cycle; it is 0 after reset.
- cpu_stall = dma_active = (state != IDLE).
- Writes to DMA_TRIG while not IDLE are impossible because the CPU is stalled. Any such write is ignored.
- Outputs are combinational from mux/state; there is no extra output latency.

## Timing
- Reset values: FSM=IDLE, parity=0, i=0, P=0, open-bus register=0, source register=none.
  - cpu_r_data=0; cpu_stall=0; dma_active=0.
  - ram_wren, ram_rden, rom_rden and reg_en are all 0 while reset is high.
- CPU read in enabled cycle N → data on cpu_r_data in cycle N+1.
- CPU write takes effect at the end of its cycle; a PPU register write is a single reg_en pulse.
- DMA length:
  - trigger write in cycle T; cpu_stall high from T+1
  - total stall is 1 + 2·DMA_LEN cycles, plus 1 if ALIGN is taken (513/514 for 256)
  - cpu_stall is low in the cycle after the last WRITE
- clock_en low: FSM, counters, parity and registers are frozen. Port enables are still driven, so macros must gate them with clock_en themselves.
- Reset asserted mid-DMA: state returns to IDLE on the next edge, stall drops, and the partial transfer is abandoned.
- i wraps at DMA_LEN. With DMA_LEN=256 and page $FF, the last source address is $FFFF with no carry into the page.

## Test plan
- RAM mirror: write $5A to $0005, read $0805 and $1805 → $5A on cpu_r_data one cycle after each read.
- ROM_AW=14: rom_rdata model returns addr[7:0]; read $C012 → rom_addr=$0012, cpu_r_data=$12. Write to $8000 → rom_rden=0 and nothing changes.
- PPU window: read $3FFA → reg_en=1, reg_sel=2, reg_rw=0; cpu_r_data = reg_data_rd in the next cycle. Write $2007 ← $33 → reg_rw=1, reg_data_wr=$33.
- Open bus: read $0000 (=$77), then read $5000 → cpu_r_data=$77.
- DMA even start: preload RAM $0200–$02FF = i, write $02 to $4014 with parity 0 at DUMMY+1.
  - 256 reg writes, sel=4, data $00..$FF in order
  - stall exactly 513 cycles
- DMA odd start: same transfer with parity 1 → ALIGN taken, stall 514 cycles. Then assert reset at WRITE #10 → stall=0 and no further reg_en on the next cycle.

Source files
------------

// File: rtl/cpu_bus_dma.sv
// cpu_bus_dma: CPU-side bus controller. Decodes CPU cycles onto mirrored work
// RAM, mirrored PRG ROM and the PPU register window, and runs the sprite-DMA
// engine that stalls the CPU while it copies one page into OAMDATA.
//
// Handshake: there is no valid/ready pair. clock_en qualifies every cycle; a
// CPU cycle is accepted on each enabled edge while cpu_stall is low. While
// cpu_stall is high the CPU must hold its cycle and its inputs are ignored.
// Port enables are driven even when clock_en is low, so macros gate with it.
module cpu_bus_dma #(
    parameter int                   RAM_AW    = 11,
    parameter int                   ROM_AW    = 15,
    parameter int                   REG_SEL_W = 3,
    parameter logic [15:0]          DMA_TRIG  = 16'h4014,
    parameter logic [REG_SEL_W-1:0] DMA_DST   = 3'h4,
    parameter int                   DMA_LEN   = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clock_en,
    input  logic [15:0]          cpu_addr,
    input  logic                 cpu_r_en,
    input  logic [7:0]           cpu_w_data,
    output logic [7:0]           cpu_r_data,
    output logic                 cpu_stall,
    output logic                 dma_active,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [7:0]           ram_wdata,
    output logic                 ram_rden,
    output logic                 ram_wren,
    input  logic [7:0]           ram_rdata,
    output logic [ROM_AW-1:0]    rom_addr,
    output logic                 rom_rden,
    input  logic [7:0]           rom_rdata,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 reg_en,
    output logic                 reg_rw,
    output logic [7:0]           reg_data_wr,
    input  logic [7:0]           reg_data_rd,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {S_IDLE, S_DUMMY, S_ALIGN, S_READ, S_WRITE} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_ROM, SRC_REG} src_t;

    // Index of the final byte; the counter is 8 bits so page+index never carries.
    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    state_t     state;
    logic       parity;
    logic [7:0] cnt;
    logic [7:0] page;
    logic [7:0] open_bus;
    src_t       src;
    src_t       next_src;

    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic        hit_ram;
    logic        hit_reg;
    logic        hit_rom;
    logic        trig;

    // Bus master mux: the CPU owns the bus only while the engine is idle.
    always_comb begin
        if (state == S_IDLE) begin
            bus_addr = cpu_addr;
            bus_rd   = cpu_r_en;
            bus_wr   = !cpu_r_en;
        end else begin
            bus_addr = {page, cnt};
            bus_rd   = (state == S_READ);
            bus_wr   = 1'b0;
        end
    end

    // Address decode of whichever master currently drives the bus.
    always_comb begin
        hit_ram = (bus_addr < 16'h2000);
        hit_reg = (bus_addr[15:13] == 3'b001);
        hit_rom = bus_addr[15];
        trig    = (state == S_IDLE) && !cpu_r_en && (cpu_addr == DMA_TRIG);
    end

    // Memory and register port drive; every enable is forced low during reset.
    always_comb begin
        ram_addr  = bus_addr[RAM_AW-1:0];
        ram_wdata = cpu_w_data;
        ram_rden  = !reset && bus_rd && hit_ram;
        ram_wren  = !reset && bus_wr && hit_ram;
        rom_addr  = bus_addr[ROM_AW-1:0];
        rom_rden  = !reset && bus_rd && hit_rom;
        if (state == S_WRITE) begin
            // DMA store: forward the byte fetched by the preceding READ.
            reg_en      = !reset;
            reg_rw      = 1'b1;
            reg_sel     = DMA_DST;
            reg_data_wr = cpu_r_data;
        end else begin
            reg_en      = !reset && (bus_rd || bus_wr) && hit_reg;
            reg_rw      = bus_wr;
            reg_sel     = bus_addr[REG_SEL_W-1:0];
            reg_data_wr = cpu_w_data;
        end
    end

    // Which port will own read data next cycle; writes and unmapped reads hold open bus.
    always_comb begin
        if (bus_rd && hit_ram)      next_src = SRC_RAM;
        else if (bus_rd && hit_rom) next_src = SRC_ROM;
        else if (bus_rd && hit_reg) next_src = SRC_REG;
        else                        next_src = SRC_NONE;
    end

    // Read data return mux, falling back to the open-bus latch.
    always_comb begin
        case (src)
            SRC_RAM: cpu_r_data = ram_rdata;
            SRC_ROM: cpu_r_data = rom_rdata;
            SRC_REG: cpu_r_data = reg_data_rd;
            default: cpu_r_data = open_bus;
        endcase
    end

    // Read-source and open-bus registers, frozen when clock_en is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            src      <= SRC_NONE;
            open_bus <= 8'h00;
        end else if (clock_en) begin
            src      <= next_src;
            open_bus <= cpu_r_data;
        end
    end

    // DMA sequencer with cycle parity, page latch and byte counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            parity <= 1'b0;
            cnt    <= 8'h00;
            page   <= 8'h00;
        end else if (clock_en) begin
            parity <= !parity;
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        state <= S_DUMMY;
                        page  <= cpu_w_data;
                        cnt   <= 8'h00;
                    end
                end
                // Parity flips on this edge; READ must land on an even cycle.
                S_DUMMY: state <= parity ? S_READ : S_ALIGN;
                S_ALIGN: state <= S_READ;
                S_READ:  state <= S_WRITE;
                S_WRITE: begin
                    cnt   <= cnt + 8'd1;
                    state <= (cnt == LAST_IDX) ? S_IDLE : S_READ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stall and status follow the FSM directly.
    always_comb begin
        cpu_stall  = (state != S_IDLE);
        dma_active = (state != S_IDLE);
        dbg_state  = state;
    end

endmodule
